// File: rtl/comm_event_capture_if.sv
// comm_event_capture_if: monitored NoC link plus the event record stream and drop status
interface comm_event_capture_if #(
  parameter int TAM_FLIT = 16,
  parameter int TS_WIDTH = 32
);
  logic                mon_tx;
  logic                mon_credit;
  logic [TAM_FLIT-1:0] mon_data;
  logic                ev_valid;
  logic                ev_ready;
  logic [15:0]         ev_service;
  logic [15:0]         ev_task_dst;
  logic [15:0]         ev_task_src;
  logic [TS_WIDTH-1:0] ev_t_start;
  logic [TS_WIDTH-1:0] ev_t_end;
  logic [15:0]         ev_flits;
  logic [15:0]         ev_stalls;
  logic [15:0]         drop_count;
  logic                overflow;
  modport master (
    input  mon_tx, mon_credit, mon_data, ev_ready,
    output ev_valid, ev_service, ev_task_dst, ev_task_src, ev_t_start, ev_t_end,
           ev_flits, ev_stalls, drop_count, overflow
  );
  modport slave (
    output mon_tx, mon_credit, mon_data, ev_ready,
    input  ev_valid, ev_service, ev_task_dst, ev_task_src, ev_t_start, ev_t_end,
           ev_flits, ev_stalls, drop_count, overflow
  );
endinterface

// File: rtl/comm_event_capture.sv
// comm_event_capture: decodes packets on one NoC port into timestamped event records held in a FWFT FIFO
module comm_event_capture #(
  parameter int          TAM_FLIT   = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TS_WIDTH   = 32,
  parameter logic [15:0] SERV_A     = 16'h0010,
  parameter logic [15:0] SERV_B     = 16'h0020,
  parameter logic [15:0] SERV_C     = 16'h0070,
  parameter bit          FILTER_EN  = 1'b1
) (
  input logic rel,
  input logic reset,
  comm_event_capture_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 5 * 16 + 2 * TS_WIDTH;
  typedef enum logic [1:0] {HEADER, SIZE, PAYLOAD} state_t;
  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, t_start_q, t_start_d;
  logic [15:0]         rem_q, rem_d, flits_q, flits_d, stalls_q, stalls_d;
  logic [15:0]         svc_q, svc_d, dst_q, dst_d, src_q, src_d, drop_q, drop_d;
  logic [1:0]          idx_q, idx_d;
  logic                ovf_q;
  logic [RW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q;
  logic                xfer, stall, last, match, push, pop, full, wr, drop;
  logic [15:0]         data, flits_inc, stalls_inc, rec_svc, rec_dst, rec_src;
  logic [RW-1:0]       rec, head;
  assign data       = bus.mon_data[15:0];
  assign xfer       = bus.mon_tx && bus.mon_credit;
  assign stall      = bus.mon_tx && !bus.mon_credit;
  assign flits_inc  = &flits_q ? flits_q : flits_q + 1'b1;
  assign stalls_inc = &stalls_q ? stalls_q : stalls_q + 1'b1;
  // the flit arriving now supplies its own field, so short packets need no extra cycle
  assign rec_svc    = idx_q == 2'd0 ? data : svc_q;
  assign rec_dst    = idx_q == 2'd1 ? data : dst_q;
  assign rec_src    = idx_q == 2'd2 ? data : src_q;
  assign last       = state_q == PAYLOAD && xfer && rem_q == 16'd1;
  assign match      = !FILTER_EN || rec_svc == SERV_A || rec_svc == SERV_B || rec_svc == SERV_C;
  assign push       = last && match;
  assign rec        = {rec_svc, rec_dst, rec_src, t_start_q, ts_q, flits_inc, stalls_q};
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    flits_d   = flits_q;
    stalls_d  = stalls_q;
    t_start_d = t_start_q;
    svc_d     = svc_q;
    dst_d     = dst_q;
    src_d     = src_q;
    unique case (state_q)
      HEADER: if (xfer) begin
        t_start_d = ts_q;
        flits_d   = 16'd1;
        stalls_d  = '0;
        svc_d     = '0;
        dst_d     = '0;
        src_d     = '0;
        state_d   = SIZE;
      end
      SIZE: if (xfer) begin
        rem_d   = data;
        flits_d = flits_inc;
        idx_d   = '0;
        state_d = data == '0 ? HEADER : PAYLOAD;
      end else if (stall) stalls_d = stalls_inc;
      PAYLOAD: if (xfer) begin
        flits_d = flits_inc;
        rem_d   = rem_q - 1'b1;
        idx_d   = &idx_q ? idx_q : idx_q + 1'b1;
        svc_d   = rec_svc;
        dst_d   = rec_dst;
        src_d   = rec_src;
        state_d = rem_q == 16'd1 ? HEADER : PAYLOAD;
      end else if (stall) stalls_d = stalls_inc;
      default: state_d = HEADER;
    endcase
  end
  assign pop    = cnt_q != '0 && bus.ev_ready;
  assign full   = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign wr     = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign drop_d = drop && !(&drop_q) ? drop_q + 1'b1 : drop_q;
  assign head   = mem_q[rd_q];
  always_ff @(posedge rel) begin
    if (reset) begin
      state_q   <= HEADER;
      ts_q      <= '0;
      t_start_q <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      flits_q   <= '0;
      stalls_q  <= '0;
      svc_q     <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_q + 1'b1;
      t_start_q <= t_start_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      flits_q   <= flits_d;
      stalls_q  <= stalls_d;
      svc_q     <= svc_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      wr_q      <= wr_q + AW'(wr);
      rd_q      <= rd_q + AW'(pop);
      cnt_q     <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
      drop_q    <= drop_d;
      ovf_q     <= ovf_q | drop;
    end
  end
  always_ff @(posedge rel) begin
    if (wr) mem_q[wr_q] <= rec;
  end
  // storage is not reset, so an empty FIFO presents zeros rather than stale entries
  assign bus.ev_valid = cnt_q != '0;
  assign {bus.ev_service, bus.ev_task_dst, bus.ev_task_src, bus.ev_t_start, bus.ev_t_end,
          bus.ev_flits, bus.ev_stalls} = bus.ev_valid ? head : '0;
  assign bus.drop_count = drop_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_comm_event_capture.sv
// tb_comm_event_capture: directed packets with a scoreboard of expected event records per instance
module tb_comm_event_capture;
  typedef struct {
    logic [15:0] svc, dst, src, fl, st;
    logic [31:0] ts, te;
  } rec_t;
  logic rel = 1'b0;
  logic reset;
  logic [31:0] tb_ts;
  int n_cmp = 0, n_err = 0;
  rec_t q0[$], q1[$];
  always #5 rel = ~rel;
  always @(posedge rel) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;
  comm_event_capture_if #(.TAM_FLIT(16), .TS_WIDTH(32)) a ();
  comm_event_capture_if #(.TAM_FLIT(16), .TS_WIDTH(4)) b ();
  comm_event_capture #(.FILTER_EN(1'b1)) dut0 (.rel(rel), .reset(reset), .bus(a));
  comm_event_capture #(.TS_WIDTH(4), .FILTER_EN(1'b0)) dut1 (.rel(rel), .reset(reset), .bus(b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pop_chk(input int s);
    rec_t e;
    if (s == 0) begin
      if (q0.size() == 0) chk("spurious_ev0", 32'(a.ev_valid), 32'd0);
      else begin
        e = q0.pop_front();
        chk("svc0", 32'(a.ev_service), 32'(e.svc));
        chk("dst0", 32'(a.ev_task_dst), 32'(e.dst));
        chk("src0", 32'(a.ev_task_src), 32'(e.src));
        chk("tstart0", a.ev_t_start, e.ts);
        chk("tend0", a.ev_t_end, e.te);
        chk("flits0", 32'(a.ev_flits), 32'(e.fl));
        chk("stalls0", 32'(a.ev_stalls), 32'(e.st));
      end
    end else begin
      if (q1.size() == 0) chk("spurious_ev1", 32'(b.ev_valid), 32'd0);
      else begin
        e = q1.pop_front();
        chk("svc1", 32'(b.ev_service), 32'(e.svc));
        chk("dst1", 32'(b.ev_task_dst), 32'(e.dst));
        chk("src1", 32'(b.ev_task_src), 32'(e.src));
        chk("tstart1", 32'(b.ev_t_start), e.ts);
        chk("tend1", 32'(b.ev_t_end), e.te);
        chk("flits1", 32'(b.ev_flits), 32'(e.fl));
        chk("stalls1", 32'(b.ev_stalls), 32'(e.st));
      end
    end
  endtask
  // s selects the driven link (0 = dut0, 1 = dut1, other = both idle); t returns the timestamp seen at the edge
  task automatic cyc(input int s, input bit tx, input bit cr, input logic [15:0] d, output logic [31:0] t);
    a.mon_tx = s == 0 && tx;
    a.mon_credit = s == 0 && cr;
    a.mon_data = d;
    b.mon_tx = s == 1 && tx;
    b.mon_credit = s == 1 && cr;
    b.mon_data = d;
    if (a.ev_valid && a.ev_ready) pop_chk(0);
    if (b.ev_valid && b.ev_ready) pop_chk(1);
    t = tb_ts;
    @(posedge rel);
    #1;
  endtask
  task automatic idle(input int n);
    logic [31:0] t;
    repeat (n) cyc(2, 1'b0, 1'b0, 16'h0, t);
  endtask
  task automatic wait_ts(input logic [31:0] target, input logic [31:0] mask);
    logic [31:0] t;
    for (int i = 0; i < 300 && (tb_ts & mask) != target; i++) cyc(2, 1'b0, 1'b0, 16'h0, t);
  endtask
  task automatic send_pkt(input int s, input logic [15:0] size, input logic [15:0] svc, input logic [15:0] dst,
                          input logic [15:0] src, input int stall_at, input int nst, input bit keep);
    rec_t e;
    logic [31:0] t, mask;
    logic [15:0] w;
    int nfl;
    nfl = 2 + int'(size);
    mask = s == 1 ? 32'hF : 32'hFFFF_FFFF;
    for (int i = 0; i < nfl; i++) begin
      if (i == stall_at) repeat (nst) cyc(s, 1'b1, 1'b0, 16'hDEAD, t);
      w = i == 0 ? 16'h0101 : i == 1 ? size : i == 2 ? svc : i == 3 ? dst : i == 4 ? src : 16'hD000 + 16'(i);
      cyc(s, 1'b1, 1'b1, w, t);
      if (i == 0) e.ts = t & mask;
    end
    e.te  = t & mask;
    e.fl  = 16'(nfl);
    e.st  = (stall_at >= 1 && stall_at < nfl) ? 16'(nst) : 16'd0;
    e.svc = svc;
    e.dst = size >= 2 ? dst : 16'd0;
    e.src = size >= 3 ? src : 16'd0;
    if (size != 0 && keep && (s == 1 || svc == 16'h0010 || svc == 16'h0020 || svc == 16'h0070)) begin
      if (s == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask
  initial begin
    logic [31:0] t;
    reset = 1'b1;
    a.mon_tx = 1'b0; a.mon_credit = 1'b0; a.mon_data = '0; a.ev_ready = 1'b1;
    b.mon_tx = 1'b0; b.mon_credit = 1'b0; b.mon_data = '0; b.ev_ready = 1'b1;
    repeat (2) @(posedge rel);
    #1;
    reset = 1'b0;
    chk("rst_valid", 32'(a.ev_valid), 32'd0);
    chk("rst_svc", 32'(a.ev_service), 32'd0);
    chk("rst_dst", 32'(a.ev_task_dst), 32'd0);
    chk("rst_src", 32'(a.ev_task_src), 32'd0);
    chk("rst_tstart", a.ev_t_start, 32'd0);
    chk("rst_tend", a.ev_t_end, 32'd0);
    chk("rst_flits", 32'(a.ev_flits), 32'd0);
    chk("rst_stalls", 32'(a.ev_stalls), 32'd0);
    chk("rst_drop", 32'(a.drop_count), 32'd0);
    chk("rst_ovf", 32'(a.overflow), 32'd0);
    chk("rst_valid1", 32'(b.ev_valid), 32'd0);
    // basic packet with header at timestamp 100; the record must be visible one cycle after the last flit
    wait_ts(32'd100, 32'hFFFF_FFFF);
    send_pkt(0, 16'd5, 16'h0020, 16'h0102, 16'h0201, -1, 0, 1'b1);
    chk("lat_valid", 32'(a.ev_valid), 32'd1);
    idle(3);
    send_pkt(0, 16'd5, 16'h0020, 16'h0102, 16'h0201, 4, 3, 1'b1);
    idle(3);
    send_pkt(0, 16'd1, 16'h0070, 16'h0102, 16'h0201, -1, 0, 1'b1);
    idle(3);
    send_pkt(0, 16'd0, 16'h0000, 16'h0000, 16'h0000, -1, 0, 1'b1);
    idle(2);
    chk("size0_none", 32'(a.ev_valid), 32'd0);
    send_pkt(0, 16'd3, 16'h0040, 16'h0102, 16'h0201, -1, 0, 1'b1);
    idle(2);
    chk("filter_none", 32'(a.ev_valid), 32'd0);
    // back-to-back packets into a stalled consumer: eight held, two dropped
    a.ev_ready = 1'b0;
    for (int k = 0; k < 10; k++) send_pkt(0, 16'd1, 16'h0010, 16'h0, 16'h0, -1, 0, k < 8);
    idle(2);
    chk("full_drop", 32'(a.drop_count), 32'd2);
    chk("full_ovf", 32'(a.overflow), 32'd1);
    chk("hold_valid", 32'(a.ev_valid), 32'd1);
    chk("hold_tstart", a.ev_t_start, q0[0].ts);
    idle(1);
    chk("hold_tstart2", a.ev_t_start, q0[0].ts);
    a.ev_ready = 1'b1;
    idle(10);
    chk("drained_valid", 32'(a.ev_valid), 32'd0);
    chk("ovf_sticky", 32'(a.overflow), 32'd1);
    chk("drained_count", 32'(q0.size()), 32'd0);
    // reset after the service flit discards the partial packet
    cyc(0, 1'b1, 1'b1, 16'h0101, t);
    cyc(0, 1'b1, 1'b1, 16'h0003, t);
    cyc(0, 1'b1, 1'b1, 16'h0010, t);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst2_ovf", 32'(a.overflow), 32'd0);
    chk("rst2_drop", 32'(a.drop_count), 32'd0);
    chk("rst2_valid", 32'(a.ev_valid), 32'd0);
    send_pkt(0, 16'd3, 16'h0010, 16'h0011, 16'h0012, -1, 0, 1'b1);
    idle(3);
    // narrow timestamp instance: header two ticks before wrap, unfiltered service
    wait_ts(32'd14, 32'hF);
    send_pkt(1, 16'd3, 16'h0040, 16'h0102, 16'h0201, -1, 0, 1'b1);
    idle(3);
    chk("left0", 32'(q0.size()), 32'd0);
    chk("left1", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/comm_event_capture.md
Name: comm_event_capture

Overview:
- Synthesizable per-PE packet monitor on one local NoC port (PE->router tx or router->PE rx direction).
- Decodes each packet (header, size, service, target task, source task), timestamps it, and counts transferred flits and stall cycles.
- Pushes one event record per selected packet into an internal FIFO.
- The log writer downstream drains the FIFO with a valid/ready handshake, so it no longer decodes raw flits itself.

Parameters:
- TAM_FLIT, 16, flit width in bits; service and task-id fields are bits [15:0].
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- TS_WIDTH, 32, width of the free-running timestamp counter and time fields.
- SERV_A, 16'h0010, first captured service code.
- SERV_B, 16'h0020, second captured service code.
- SERV_C, 16'h0070, third captured service code (task terminated).
- FILTER_EN, 1, 1 = record only SERV_A/B/C packets; 0 = record every packet that carries a service flit.

Ports:
- rel  input  1  clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high
- mon_tx  input  1  sender valid on the monitored link
- mon_credit  input  1  receiver credit on the monitored link; a flit transfers when mon_tx && mon_credit
- mon_data  input  TAM_FLIT  flit on the monitored link
- ev_valid  output  1  FIFO head holds an event
- ev_ready  input  1  consumer accepts the head when ev_valid && ev_ready
- ev_service  output  16  service code
- ev_task_dst  output  16  target task id (0 if absent)
- ev_task_src  output  16  source task id (0 if absent)
- ev_t_start  output  TS_WIDTH  timestamp of the header-flit transfer
- ev_t_end  output  TS_WIDTH  timestamp of the last-flit transfer
- ev_flits  output  16  flits transferred, including header and size flits
- ev_stalls  output  16  cycles with mon_tx=1 and mon_credit=0 inside the packet
- drop_count  output  16  events lost to a full FIFO; saturates at 16'hFFFF
- overflow  output  1  sticky, set on first drop; cleared only by reset

Behaviour:
- Reset (synchronous, 1 cycle):
  - Clears timestamp, FSM, FIFO pointers and counters.
  - ev_valid=0, all ev_* fields=0, drop_count=0, overflow=0.
  - Reset mid-packet discards the partial packet; the next accepted flit is treated as a header.
- Timestamp: increments by 1 every cycle; wraps modulo 2^TS_WIDTH. No wrap correction; the consumer computes end minus start modulo 2^TS_WIDTH.
- Transfer: xfer = mon_tx && mon_credit. Every field capture and flit count happens only on xfer.
- FSM states and transitions:
  - HEADER: on xfer latch t_start = timestamp, set flits=1, stalls=0; go to SIZE.
  - SIZE: on xfer latch remaining = mon_data[15:0], flits+1.
    - remaining = 0: packet ends on this transfer with no service; push nothing; go to HEADER.
    - Otherwise go to PAYLOAD with payload index idx=0.
  - PAYLOAD: on xfer, flits+1 (saturating at 16'hFFFF), remaining-1.
    - idx=0 latches service; idx=1 latches task_dst; idx=2 latches task_src; later flits are counted only.
    - When remaining reaches 0 the packet ends; go to HEADER.
- Stall counting: in SIZE and PAYLOAD, and in HEADER after the header flit, stalls+1 (saturating) on every cycle with mon_tx=1 and mon_credit=0. Idle cycles (mon_tx=0) are not counted.
- Push at packet end:
  - The record is assembled from latched fields plus the current cycle's fields (t_end = current timestamp; for a size-1 or size-2 packet the final flit's field comes from mon_data directly).
  - The record is written at the same edge as the last-flit transfer. ev_valid is visible from the next cycle (latency 1).
  - Push happens only if a service was latched and, when FILTER_EN=1, the service matches SERV_A, SERV_B or SERV_C.
  - Fields not yet received are 0.
- FIFO:
  - First-word-fall-through: head fields are registered and stable while ev_valid && !ev_ready.
  - Push while full with no pop in the same cycle: record dropped, drop_count+1 (saturating), overflow=1.
  - Push and pop in the same cycle while full: push succeeds, occupancy unchanged.
  - Pop while empty: ignored.
- Back-to-back packets: a header may transfer in the cycle immediately after the last flit. No idle cycle is required.

Test Plan:
- Packet header=0x0101, size=5, service=0x0020, dst=0x0102, src=0x0201, two data flits, mon_credit held 1, header at timestamp 100 -> one event: service 0x0020, dst 0x0102, src 0x0201, t_start 100, t_end 106, flits 7, stalls 0, ev_valid high at cycle 107.
- Same packet with mon_credit low for 3 cycles after the dst flit -> t_end 109, flits 7, stalls 3.
- Packet with size=1, service=0x0070 -> event with dst=0, src=0, flits 3. Packet with size=0 -> no event. Service 0x0040 with FILTER_EN=1 -> no event; with FILTER_EN=0 -> event recorded.
- FIFO_DEPTH=8, ev_ready=0, ten back-to-back 0x0010 packets -> 8 events held, drop_count=2, overflow=1. Then ev_ready=1 -> 8 events drained in arrival order; overflow stays 1.
- Reset asserted for 1 cycle after the service flit of a packet, then a full 0x0010 packet -> only the second packet is recorded, with flits counted from its own header.
- Timestamp preloaded near wrap (header at 2^32-2, 5-flit packet) -> t_start 0xFFFFFFFE, t_end 0x00000002.
